// File: rtl/ps2_key_sequencer_pkg.sv
// Shared scan-code constants and state encodings for the PS/2 key sequencer.
package ps2_key_sequencer_pkg;

   localparam logic [7:0] SCAN_BREAK = 8'hF0;
   localparam logic [7:0] SCAN_EXT   = 8'hE0;
   localparam logic [7:0] SCAN_BKSP  = 8'h66;

   typedef enum logic [1:0] {
      FR_IDLE   = 2'd0,
      FR_DATA   = 2'd1,
      FR_PARITY = 2'd2,
      FR_STOP   = 2'd3
   } frame_state_e;

   typedef enum logic [1:0] {
      DEC_NORMAL    = 2'd0,
      DEC_BREAK     = 2'd1,
      DEC_EXT       = 2'd2,
      DEC_EXT_BREAK = 2'd3
   } dec_state_e;

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// PS/2 line inputs and digit-buffer control outputs of the key sequencer.
interface ps2_key_sequencer_if;
   logic       ps2clk;
   logic       ps2data;
   logic [7:0] key_code;
   logic       push;
   logic       pop;
   logic [3:0] depth;
   logic       full;
   logic       empty;
   logic       frame_err;

   modport master (
      output ps2clk, ps2data,
      input  key_code, push, pop, depth, full, empty, frame_err
   );

   modport slave (
      input  ps2clk, ps2data,
      output key_code, push, pop, depth, full, empty, frame_err
   );
endinterface

// File: rtl/ps2_key_sequencer_frame_rx.sv
// PS/2 line synchronizer and 11-bit frame receiver with inactivity timeout.
// state  | meaning
// IDLE   | waiting for a start bit (0) on a falling edge
// DATA   | shifting 8 data bits, LSB first
// PARITY | checking odd parity over data+parity
// STOP   | stop bit decides accept or reject
module ps2_frame_rx
   import ps2_key_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2clk_i,
   input  logic       ps2data_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       err_o
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   frame_state_e     state_q;
   logic [2:0]       bitcnt_q;
   logic [7:0]       sr_q;
   logic             perr_q;
   logic [TMO_W-1:0] tmo_q;
   logic             clk_s1_q, clk_s2_q, clk_s3_q;
   logic             dat_s1_q, dat_s2_q;

   logic fall, timeout, stop_ok;

   assign fall    = clk_s3_q & ~clk_s2_q;
   assign timeout = (state_q != FR_IDLE) && !fall && (tmo_q == TMO_LAST);
   assign stop_ok = dat_s2_q && !perr_q;

   assign byte_o  = sr_q;
   assign valid_o = fall && (state_q == FR_STOP) && stop_ok;
   assign err_o   = (fall && (state_q == FR_STOP) && !stop_ok) || timeout;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= FR_IDLE;
         bitcnt_q <= 3'd0;
         sr_q     <= 8'h00;
         perr_q   <= 1'b0;
         tmo_q    <= '0;
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2clk_i;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2data_i;
         dat_s2_q <= dat_s1_q;

         if (state_q != FR_IDLE && !fall)
            tmo_q <= timeout ? '0 : tmo_q + TMO_W'(1);
         else
            tmo_q <= '0;

         if (timeout) begin
            state_q <= FR_IDLE;
         end else if (fall) begin
            case (state_q)
               FR_IDLE: begin
                  if (!dat_s2_q) begin
                     state_q  <= FR_DATA;
                     bitcnt_q <= 3'd0;
                  end
               end
               FR_DATA: begin
                  sr_q     <= {dat_s2_q, sr_q[7:1]};
                  bitcnt_q <= bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7)
                     state_q <= FR_PARITY;
               end
               FR_PARITY: begin
                  // data+parity must hold an odd number of ones
                  perr_q  <= ~(^sr_q ^ dat_s2_q);
                  state_q <= FR_STOP;
               end
               default: state_q <= FR_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns PS/2 make/break scan bytes into push/pop strobes for a digit buffer.
// state     | meaning
// NORMAL    | next byte is a make, prefix or backspace
// BREAK     | swallow released key code
// EXT       | extended prefix seen, key not displayable
// EXT_BREAK | swallow released extended key code
module ps2_key_sequencer
   import ps2_key_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int DEPTH          = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   ps2_key_sequencer_if.slave  kbd_io
);

   localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_err;

   dec_state_e dec_q;
   logic [7:0] key_code_q;
   logic       push_q, pop_q, frame_err_q;
   logic [3:0] depth_q;

   ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_rx (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .ps2clk_i  (kbd_io.ps2clk),
      .ps2data_i (kbd_io.ps2data),
      .byte_o    (rx_byte),
      .valid_o   (rx_valid),
      .err_o     (rx_err)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dec_q       <= DEC_NORMAL;
         key_code_q  <= 8'h00;
         push_q      <= 1'b0;
         pop_q       <= 1'b0;
         frame_err_q <= 1'b0;
         depth_q     <= 4'd0;
      end else begin
         push_q      <= 1'b0;
         pop_q       <= 1'b0;
         frame_err_q <= 1'b0;
         if (rx_err) begin
            frame_err_q <= 1'b1;
            dec_q       <= DEC_NORMAL;
         end else if (rx_valid) begin
            case (dec_q)
               DEC_NORMAL: begin
                  if (rx_byte == SCAN_BREAK) begin
                     dec_q <= DEC_BREAK;
                  end else if (rx_byte == SCAN_EXT) begin
                     dec_q <= DEC_EXT;
                  end else if (rx_byte == SCAN_BKSP) begin
                     if (depth_q != 4'd0) begin
                        pop_q   <= 1'b1;
                        depth_q <= depth_q - 4'd1;
                     end
                  end else begin
                     // when full the oldest digit falls off, depth stays put
                     push_q     <= 1'b1;
                     key_code_q <= rx_byte;
                     if (depth_q != DEPTH_MAX)
                        depth_q <= depth_q + 4'd1;
                  end
               end
               DEC_EXT:  dec_q <= (rx_byte == SCAN_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
               default:  dec_q <= DEC_NORMAL;
            endcase
         end
      end
   end

   assign kbd_io.key_code  = key_code_q;
   assign kbd_io.push      = push_q;
   assign kbd_io.pop       = pop_q;
   assign kbd_io.frame_err = frame_err_q;
   assign kbd_io.depth     = depth_q;
   assign kbd_io.full      = (depth_q == DEPTH_MAX);
   assign kbd_io.empty     = (depth_q == 4'd0);

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: PS/2 frames in, push/pop/depth out.
module tb_ps2_key_sequencer;
   localparam int TMO = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ps2_key_sequencer_if kbd();

   ps2_key_sequencer #(.TIMEOUT_CYCLES(TMO), .DEPTH(8)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .kbd_io (kbd)
   );

   int n_cmp = 0;
   int n_err = 0;
   int push_cyc = 0, pop_cyc = 0, err_cyc = 0, both_cyc = 0;
   logic [7:0] last_key = 8'h00;

   always @(negedge clk) begin
      if (!rst) begin
         if (kbd.push) begin
            push_cyc = push_cyc + 1;
            last_key = kbd.key_code;
         end
         if (kbd.pop)             pop_cyc  = pop_cyc + 1;
         if (kbd.frame_err)       err_cyc  = err_cyc + 1;
         if (kbd.push && kbd.pop) both_cyc = both_cyc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      kbd.ps2data = b;
      repeat (5) @(posedge clk);
      kbd.ps2clk = 1'b0;
      repeat (10) @(posedge clk);
      kbd.ps2clk = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~^b ^ bad_par);
      send_bit(1'b1);
      kbd.ps2data = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   task automatic send_partial(input int nbits);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(i[0]);
      kbd.ps2data = 1'b1;
   endtask

   logic [7:0] makes [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   initial begin
      kbd.ps2clk  = 1'b1;
      kbd.ps2data = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_key_code", kbd.key_code, 8'h00);
      chk("rst_push", kbd.push, 1'b0);
      chk("rst_pop", kbd.pop, 1'b0);
      chk("rst_frame_err", kbd.frame_err, 1'b0);
      chk("rst_depth", kbd.depth, 4'd0);
      chk("rst_empty", kbd.empty, 1'b1);
      chk("rst_full", kbd.full, 1'b0);
      rst = 1'b0;
      repeat (5) @(posedge clk);

      send_frame(8'h1C, 1'b0);
      @(negedge clk);
      chk("make1c_push", push_cyc, 1);
      chk("make1c_key", last_key, 8'h1C);
      chk("make1c_depth", kbd.depth, 4'd1);
      chk("make1c_empty", kbd.empty, 1'b0);

      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      @(negedge clk);
      chk("break_push", push_cyc, 1);
      chk("break_pop", pop_cyc, 0);
      chk("break_depth", kbd.depth, 4'd1);

      send_frame(8'h66, 1'b0);
      @(negedge clk);
      chk("bksp_pop", pop_cyc, 1);
      chk("bksp_depth", kbd.depth, 4'd0);
      chk("bksp_empty", kbd.empty, 1'b1);
      send_frame(8'h66, 1'b0);
      @(negedge clk);
      chk("bksp_empty_pop", pop_cyc, 1);
      chk("bksp_empty_depth", kbd.depth, 4'd0);
      chk("bksp_empty_err", err_cyc, 0);

      for (int i = 0; i < 9; i++) send_frame(makes[i], 1'b0);
      @(negedge clk);
      chk("nine_push", push_cyc, 10);
      chk("nine_depth", kbd.depth, 4'd8);
      chk("nine_full", kbd.full, 1'b1);
      chk("nine_key", last_key, 8'h46);
      chk("nine_key_hold", kbd.key_code, 8'h46);

      send_frame(8'h1C, 1'b1);
      @(negedge clk);
      chk("badpar_err", err_cyc, 1);
      chk("badpar_push", push_cyc, 10);
      send_frame(8'hE0, 1'b0);
      send_frame(8'h74, 1'b0);
      @(negedge clk);
      chk("ext_push", push_cyc, 10);
      chk("ext_depth", kbd.depth, 4'd8);

      // a bad frame after an E0 prefix must leave the decoder in NORMAL
      send_frame(8'hE0, 1'b0);
      send_frame(8'h55, 1'b1);
      send_frame(8'h1C, 1'b0);
      @(negedge clk);
      chk("errclr_err", err_cyc, 2);
      chk("errclr_push", push_cyc, 11);
      chk("errclr_depth", kbd.depth, 4'd8);

      send_partial(4);
      repeat (TMO + 20) @(posedge clk);
      @(negedge clk);
      chk("tmo_err", err_cyc, 3);
      chk("tmo_push", push_cyc, 11);
      chk("tmo_both", both_cyc, 0);
      send_frame(8'h45, 1'b0);
      @(negedge clk);
      chk("tmo_next_push", push_cyc, 12);
      chk("tmo_next_key", last_key, 8'h45);

      for (int i = 0; i < 5; i++) send_frame(8'h66, 1'b0);
      @(negedge clk);
      chk("pop5_pop", pop_cyc, 6);
      chk("pop5_depth", kbd.depth, 4'd3);

      send_partial(3);
      #3 rst = 1'b1;
      #2;
      chk("midrst_depth", kbd.depth, 4'd0);
      chk("midrst_empty", kbd.empty, 1'b1);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      repeat (TMO + 20) @(posedge clk);
      @(negedge clk);
      chk("midrst_no_err", err_cyc, 3);
      chk("midrst_key", kbd.key_code, 8'h00);
      send_frame(8'h1C, 1'b0);
      @(negedge clk);
      chk("midrst_push", push_cyc, 13);
      chk("midrst_push_key", last_key, 8'h1C);
      chk("midrst_depth1", kbd.depth, 4'd1);
      chk("final_both", both_cyc, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000; CLK cycles without a PS/2 clock falling edge before a partial frame is abandoned.
REQ-002 Parameter DEPTH, default 8; number of seven-segment digit slots in the downstream key buffer.
REQ-003 CLK  input  1  system clock; one clock only, all logic on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 ps2clk  input  1  raw PS/2 clock line, asynchronous to CLK.
REQ-006 ps2data  input  1  raw PS/2 data line, asynchronous to CLK.
REQ-007 key_code  output  8  last accepted make code; valid while push is high.
REQ-008 push  output  1  one-cycle strobe: shift key_code into digit 0, all digits move up one slot.
REQ-009 pop  output  1  one-cycle strobe: backspace, all digits move down one slot.
REQ-010 depth  output  4  number of occupied digit slots, 0..DEPTH.
REQ-011 full / empty  output  1 each  depth==DEPTH / depth==0.
REQ-012 frame_err  output  1  one-cycle strobe on a rejected or timed-out frame.

Function
REQ-013 ps2clk and ps2data SHALL each pass through a 2-flop synchronizer; a falling edge is synced ps2clk previous=1, current=0.
REQ-014 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP; bits are sampled only on the falling-edge cycle.
REQ-015 IDLE: sampled 0 -> DATA with bit counter 0; sampled 1 -> stay IDLE, no error.
REQ-016 DATA: 8 bits SHALL be shifted in LSB first; after bit 7 -> PARITY.
REQ-017 PARITY: sampled bit SHALL make the total count of ones over data+parity odd; otherwise an error flag is latched; -> STOP.
REQ-018 STOP: sampled 1 with no parity error -> byte accepted; otherwise frame_err pulses; -> IDLE in both cases.
REQ-019 In DATA, PARITY or STOP, TIMEOUT_CYCLES consecutive cycles without a falling edge SHALL force IDLE and pulse frame_err; the partial byte is discarded.
REQ-020 Decode FSM states SHALL be NORMAL, BREAK, EXT, EXT_BREAK, acting on accepted bytes only.
REQ-021 NORMAL: 0xF0 -> BREAK; 0xE0 -> EXT; 0x66 -> pop request; any other byte -> push request with key_code=byte.
REQ-022 BREAK: next byte is swallowed (key release) -> NORMAL.
REQ-023 EXT: 0xF0 -> EXT_BREAK; any other byte swallowed -> NORMAL (extended keys not displayable).
REQ-024 EXT_BREAK: next byte swallowed -> NORMAL.
REQ-025 push/pop SHALL assert exactly one CLK cycle, on the cycle after the STOP-sampling cycle; never both together.
REQ-026 push at depth<DEPTH: depth+1; push at full: push still asserted (oldest digit drops off), depth stays DEPTH.
REQ-027 pop at depth>0: depth-1; pop request at empty: pop suppressed, depth stays 0, no error.
REQ-028 key_code SHALL hold its value between pushes.
REQ-029 frame_err SHALL reset the decode FSM to NORMAL.

Reset
REQ-030 RST high SHALL immediately force both FSMs to IDLE/NORMAL, bit counter and timeout counter 0, synchronizer flops 1.
REQ-031 During/after reset: key_code=0x00, push=0, pop=0, frame_err=0, depth=0, empty=1, full=0.
REQ-032 Reset mid-frame SHALL discard the partial byte without a frame_err pulse.

Structure
REQ-033 Shared package SHALL hold the scan constants (0xF0 break, 0xE0 extended, 0x66 backspace), the frame-FSM and decode-FSM state encodings.
REQ-034 One sub-module, ps2_frame_rx (synchronizer, edge detect, frame FSM, timeout), SHALL emit byte+valid+error to the decode/depth logic in the top.

Verification
REQ-035 Frame 0x1C, odd parity 0, stop 1 -> push one cycle with key_code=0x1C, depth 0->1.
REQ-036 Bytes F0,1C after 0x1C make -> no push/pop, depth unchanged; then 0x66 -> pop, depth 1->0; a second 0x66 -> no pop, depth 0.
REQ-037 Nine distinct makes (0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46) -> nine pushes, depth saturates at 8, full=1.
REQ-038 Frame 0x1C with wrong parity bit 1 -> frame_err one cycle, no push; E0,74 -> no push.
REQ-039 Four bits then ps2clk held high for TIMEOUT_CYCLES -> frame_err one cycle, FSM IDLE; next good 0x45 frame -> push 0x45.
REQ-040 RST asserted mid-DATA with depth=3 -> depth=0, empty=1, no frame_err; following 0x1C frame -> push 0x1C.
